// File: rtl/bcd_scan_capture_pkg.sv
// rtl/bcd_scan_capture_pkg.sv - shared types and segment constants for the scan capture block
package bcd_scan_capture_pkg;

  // Frame controller states: collecting digits, or holding a presented frame.
  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Active-low segment patterns, bit0 = a ... bit6 = g, lit segment = 0.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;

  // Nibble reported for any pattern that is not a decimal digit.
  localparam logic [3:0] BCD_INVALID = 4'hF;

endpackage

// File: rtl/bcd_scan_capture_if.sv
// rtl/bcd_scan_capture_if.sv - frame output handshake bundle
interface bcd_scan_capture_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_bcd;
  logic [3:0]  frame_err;

  modport master (
    output frame_valid,
    output frame_bcd,
    output frame_err,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_bcd,
    input  frame_err,
    output frame_ready
  );
endinterface

// File: rtl/bcd_scan_capture_seg7_to_bcd.sv
// rtl/bcd_scan_capture_seg7_to_bcd.sv - combinational active-low 7-segment to BCD decoder
module seg7_to_bcd
  import bcd_scan_capture_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] bcd_o,
  output logic       invalid_o
);

  // Map each legal digit pattern to its value; everything else is flagged invalid.
  always_comb begin
    bcd_o     = BCD_INVALID;
    invalid_o = 1'b0;
    case (seg_n_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/bcd_scan_capture.sv
// rtl/bcd_scan_capture.sv - captures a multiplexed 4-digit 7-segment scan into BCD frames
module bcd_scan_capture
  import bcd_scan_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         select_n,
  input  logic [6:0]         seg_n,
  bcd_scan_capture_if.master frame,
  output logic               overrun
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  logic [3:0]  sel_q, sel_p_q;
  logic [6:0]  seg_q, seg_p_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] shadow_bcd_q;
  logic [3:0]  shadow_err_q;
  logic [15:0] frame_bcd_q;
  logic [3:0]  frame_err_q;
  logic        overrun_q;
  state_e      state_q, state_d;

  logic        active_w, same_w, capture_w, seen_full_w;
  logic        load_w, drop_w, frame_valid_w;
  logic [1:0]  slot_w;
  logic [3:0]  dec_bcd_w;
  logic        dec_inv_w;

  // Input sampling plus a one-cycle history used to judge stability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 4'hF;
      seg_q   <= 7'h7F;
      sel_p_q <= 4'hF;
      seg_p_q <= 7'h7F;
    end else begin
      sel_q   <= select_n;
      seg_q   <= seg_n;
      sel_p_q <= sel_q;
      seg_p_q <= seg_q;
    end
  end

  seg7_to_bcd u_dec (
    .seg_n_i   (seg_q),
    .bcd_o     (dec_bcd_w),
    .invalid_o (dec_inv_w)
  );

  // A digit is active only when exactly one select line is low.
  always_comb begin
    active_w = 1'b1;
    slot_w   = 2'd0;
    case (sel_q)
      4'b1110: slot_w = 2'd0;
      4'b1101: slot_w = 2'd1;
      4'b1011: slot_w = 2'd2;
      4'b0111: slot_w = 2'd3;
      default: active_w = 1'b0;
    endcase
  end

  // Count identical samples of the active digit; capture once when the run hits the limit.
  always_comb begin
    same_w = (sel_q == sel_p_q) && (seg_q == seg_p_q);
    cnt_d  = cnt_q;
    if (!active_w) begin
      cnt_d = 8'd0;
    end else if (!same_w) begin
      cnt_d = 8'd1;
    end else if (cnt_q != STABLE_LIM) begin
      cnt_d = cnt_q + 8'd1;
    end
    capture_w = active_w && (cnt_d == STABLE_LIM) && (!same_w || (cnt_q != STABLE_LIM));
  end

  // A capture on the edge that consumes a full seen set starts the next frame.
  always_comb begin
    seen_full_w = (seen_q == 4'hF);
    seen_d      = seen_full_w ? 4'h0 : seen_q;
    if (capture_w) begin
      seen_d[slot_w] = 1'b1;
    end
  end

  // Stability counter, seen flags and shadow frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 8'd0;
      seen_q       <= 4'h0;
      shadow_bcd_q <= 16'h0000;
      shadow_err_q <= 4'h0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      if (capture_w) begin
        shadow_bcd_q[{slot_w, 2'b00} +: 4] <= dec_bcd_w;
        shadow_err_q[slot_w]               <= dec_inv_w;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stay in PEND on back-to-back loads or while unaccepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SCAN: if (seen_full_w) state_d = ST_PEND;
      ST_PEND: if (frame.frame_ready && !seen_full_w) state_d = ST_SCAN;
      default: state_d = ST_SCAN;
    endcase
  end

  // FSM outputs: load a completed frame when free, otherwise discard it and flag overrun.
  always_comb begin
    frame_valid_w = (state_q == ST_PEND);
    load_w        = seen_full_w && ((state_q == ST_SCAN) || frame.frame_ready);
    drop_w        = seen_full_w && (state_q == ST_PEND) && !frame.frame_ready;
  end

  // Presented frame and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_bcd_q <= 16'h0000;
      frame_err_q <= 4'h0;
      overrun_q   <= 1'b0;
    end else begin
      if (load_w) begin
        frame_bcd_q <= shadow_bcd_q;
        frame_err_q <= shadow_err_q;
      end
      if (drop_w) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign frame.frame_valid = frame_valid_w;
  assign frame.frame_bcd   = frame_bcd_q;
  assign frame.frame_err   = frame_err_q;
  assign overrun           = overrun_q;

endmodule
